// File: rtl/axis_read_ctrl_if.sv
// Config, datapath-config and AXI AR / R-snoop signals of axis_read_ctrl.
// master = controller side, slave = config source / datapath / AXI port side.
interface axis_read_ctrl_if #(
   parameter int CONFIG_DWIDTH  = 32,
   parameter int AXI_ADDR_WIDTH = 32
);
   logic [CONFIG_DWIDTH-1:0]  cfg_address;
   logic [CONFIG_DWIDTH-1:0]  cfg_length;
   logic                      cfg_valid;
   logic                      cfg_ready;
   logic [CONFIG_DWIDTH-1:0]  data_cfg_length;
   logic                      data_cfg_valid;
   logic                      data_cfg_ready;
   logic [AXI_ADDR_WIDTH-1:0] axi_araddr;
   logic [7:0]                axi_arlen;
   logic                      axi_arvalid;
   logic                      axi_arready;
   logic                      axi_rvalid;
   logic                      axi_rready;
   logic                      axi_rlast;

   modport master (
      input  cfg_address, cfg_length, cfg_valid, data_cfg_ready,
             axi_arready, axi_rvalid, axi_rready, axi_rlast,
      output cfg_ready, data_cfg_length, data_cfg_valid,
             axi_araddr, axi_arlen, axi_arvalid
   );

   modport slave (
      output cfg_address, cfg_length, cfg_valid, data_cfg_ready,
             axi_arready, axi_rvalid, axi_rready, axi_rlast,
      input  cfg_ready, data_cfg_length, data_cfg_valid,
             axi_araddr, axi_arlen, axi_arvalid
   );
endinterface

// File: rtl/axis_read_ctrl.sv
// AXI read-stream sequencer: splits one (address, length) request into AR bursts.
// Define AXIS_READ_CTRL_4K_EN to additionally stop every burst at a 4KB boundary.
module axis_read_ctrl #(
   parameter int CONFIG_DWIDTH   = 32,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int DATA_WIDTH      = 32,
   parameter int BURST_LEN       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic             clk,
   input  logic             rst,
   axis_read_ctrl_if.master bus,
   output logic             busy
);
   localparam int BPB         = AXI_DATA_WIDTH / 8;
   localparam int ADDR_LSB    = $clog2(BPB);
   localparam int WIDTH_RATIO = AXI_DATA_WIDTH / DATA_WIDTH;
   localparam int RATIO_LOG2  = $clog2(WIDTH_RATIO);
   localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
   localparam int BURST_W     = 9;

   typedef enum logic [4:0] {
      IDLE = 5'b00001,
      DCFG = 5'b00010,
      CALC = 5'b00100,
      ADDR = 5'b01000,
      DONE = 5'b10000
   } state_e;

   state_e                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CONFIG_DWIDTH-1:0]  len_q, len_d;
   logic [CONFIG_DWIDTH-1:0]  beats_left_q, beats_left_d;
   logic [BURST_W-1:0]        burst_q, burst_d;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]                arlen_q, arlen_d;
   logic [OUT_W-1:0]          outst_q, outst_d;

   logic                      ar_hs;
   logic                      rlast_hs;
   logic [CONFIG_DWIDTH:0]    len_round;
   logic [CONFIG_DWIDTH-1:0]  beats_init;
   logic [BURST_W-1:0]        burst_calc;

   assign ar_hs      = bus.axi_arvalid & bus.axi_arready;
   assign rlast_hs   = bus.axi_rvalid & bus.axi_rready & bus.axi_rlast;
   // Extra top bit keeps ceil(len / WIDTH_RATIO) correct for lengths near 2^CONFIG_DWIDTH.
   assign len_round  = {1'b0, bus.cfg_length} + (CONFIG_DWIDTH + 1)'(WIDTH_RATIO - 1);
   assign beats_init = CONFIG_DWIDTH'(len_round >> RATIO_LOG2);

`ifdef AXIS_READ_CTRL_4K_EN
   logic [12:0] beats_to_4k;
   assign beats_to_4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> ADDR_LSB;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      burst_calc = BURST_W'(BURST_LEN);
      if (beats_left_q < CONFIG_DWIDTH'(BURST_LEN)) burst_calc = BURST_W'(beats_left_q);
`ifdef AXIS_READ_CTRL_4K_EN
      if (beats_to_4k < 13'(burst_calc)) burst_calc = BURST_W'(beats_to_4k);
`endif
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      beats_left_d = beats_left_q;
      burst_d      = burst_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      case (state_q)
         IDLE: begin
            if (bus.cfg_valid) begin
               addr_d       = AXI_ADDR_WIDTH'(bus.cfg_address) & ~AXI_ADDR_WIDTH'(BPB - 1);
               len_d        = bus.cfg_length;
               beats_left_d = beats_init;
               state_d      = (bus.cfg_length == '0) ? DONE : DCFG;
            end
         end
         DCFG: if (bus.data_cfg_ready) state_d = CALC;
         CALC: begin
            // Stalling here is what keeps the outstanding counter from overflowing.
            if (outst_q != OUT_W'(MAX_OUTSTANDING)) begin
               burst_d  = burst_calc;
               arlen_d  = 8'(burst_calc - BURST_W'(1));
               araddr_d = addr_q;
               state_d  = ADDR;
            end
         end
         ADDR: begin
            if (bus.axi_arready) begin
               addr_d       = addr_q + (AXI_ADDR_WIDTH'(burst_q) << ADDR_LSB);
               beats_left_d = beats_left_q - CONFIG_DWIDTH'(burst_q);
               state_d      = (beats_left_d == '0) ? DONE : CALC;
            end
         end
         DONE:    if (outst_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // An rlast with nothing outstanding (data left over from an aborted transfer) is dropped.
   always_comb begin
      outst_d = outst_q;
      if (ar_hs && !rlast_hs)                       outst_d = outst_q + OUT_W'(1);
      else if (!ar_hs && rlast_hs && outst_q != '0) outst_d = outst_q - OUT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         beats_left_q <= '0;
         burst_q      <= '0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         outst_q      <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         beats_left_q <= beats_left_d;
         burst_q      <= burst_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         outst_q      <= outst_d;
      end
   end

   assign bus.cfg_ready       = (state_q == IDLE);
   assign bus.data_cfg_valid  = (state_q == DCFG);
   assign bus.data_cfg_length = len_q;
   assign bus.axi_arvalid     = (state_q == ADDR);
   assign bus.axi_araddr      = araddr_q;
   assign bus.axi_arlen       = arlen_q;
   assign busy                = (state_q != IDLE);
endmodule

// File: tb/tb_axis_read_ctrl.sv
// Directed bench for axis_read_ctrl; expectations follow AXIS_READ_CTRL_4K_EN when defined.
module tb_axis_read_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   checks = 0;
   int   errors = 0;

   axis_read_ctrl_if bus_if ();

   axis_read_ctrl dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus_if),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cfg(input logic [31:0] addr, input logic [31:0] len);
      bus_if.cfg_address = addr;
      bus_if.cfg_length  = len;
      bus_if.cfg_valid   = 1'b1;
      step();
      bus_if.cfg_valid   = 1'b0;
   endtask

   task automatic pulse_rlast();
      bus_if.axi_rvalid = 1'b1;
      bus_if.axi_rready = 1'b1;
      bus_if.axi_rlast  = 1'b1;
      step();
      bus_if.axi_rvalid = 1'b0;
      bus_if.axi_rready = 1'b0;
      bus_if.axi_rlast  = 1'b0;
   endtask

   // Waits (bounded) for arvalid with arready high, records the AR and lets it handshake.
   task automatic capture_ar(output logic [31:0] a, output logic [7:0] l, output bit ok);
      ok = 1'b0;
      a  = '0;
      l  = '0;
      for (int i = 0; i < 50; i++) begin
         if (bus_if.axi_arvalid) begin
            a  = bus_if.axi_araddr;
            l  = bus_if.axi_arlen;
            ok = 1'b1;
            step();
            return;
         end
         step();
      end
   endtask

   task automatic wait_arvalid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus_if.axi_arvalid) begin
            ok = 1'b1;
            return;
         end
         step();
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (!busy) begin
            ok = 1'b1;
            return;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      checks++;
      if (bus_if.cfg_ready !== 1'b1 || busy !== 1'b0 || bus_if.data_cfg_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: cfg_ready=%b busy=%b data_cfg_valid=%b required 1 0 0",
                  bus_if.cfg_ready, busy, bus_if.data_cfg_valid);
      end
      checks++;
      if (bus_if.axi_arvalid !== 1'b0 || bus_if.axi_araddr !== 32'h0 || bus_if.axi_arlen !== 8'h0) begin
         errors++;
         $display("FAIL reset_ar: arvalid=%b araddr=%h arlen=%h required 0 0 0",
                  bus_if.axi_arvalid, bus_if.axi_araddr, bus_if.axi_arlen);
      end
   endtask

   task automatic test_basic();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok;
      logic [31:0] ea [2];
      ea[0] = 32'h1000;
      ea[1] = 32'h1080;
      start_cfg(32'h1003, 32'd64);
      checks++;
      if (bus_if.data_cfg_valid !== 1'b1 || bus_if.data_cfg_length !== 32'd64 ||
          bus_if.cfg_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_dcfg: dvalid=%b dlen=%0d cfg_ready=%b busy=%b required 1 64 0 1",
                  bus_if.data_cfg_valid, bus_if.data_cfg_length, bus_if.cfg_ready, busy);
      end
      for (int i = 0; i < 2; i++) begin
         capture_ar(a, l, ok);
         checks++;
         if (!ok || a !== ea[i] || l !== 8'd15) begin
            errors++;
            $display("FAIL basic_ar%0d: seen=%b araddr=%h arlen=%0d required %h 15", i, ok, a, l, ea[i]);
         end
      end
      pulse_rlast();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_one_rlast: busy=%b required 1", busy);
      end
      pulse_rlast();
      wait_idle(ok);
      checks++;
      if (!ok || bus_if.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_idle: idle=%b cfg_ready=%b required 1 1", ok, bus_if.cfg_ready);
      end
   endtask

   task automatic test_zero_len();
      start_cfg(32'h0500, 32'd0);
      checks++;
      if (bus_if.cfg_ready !== 1'b0 || bus_if.data_cfg_valid !== 1'b0 || bus_if.axi_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: cfg_ready=%b dvalid=%b arvalid=%b required 0 0 0",
                  bus_if.cfg_ready, bus_if.data_cfg_valid, bus_if.axi_arvalid);
      end
      step();
      checks++;
      if (bus_if.cfg_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_idle: cfg_ready=%b busy=%b required 1 0", bus_if.cfg_ready, busy);
      end
   endtask

   task automatic test_4k_split();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok;
      int          n;
      logic [31:0] ea [3];
      logic [7:0]  el [3];
`ifdef AXIS_READ_CTRL_4K_EN
      n = 3;
      ea[0] = 32'h0FF0; el[0] = 8'd1;
      ea[1] = 32'h1000; el[1] = 8'd15;
      ea[2] = 32'h1080; el[2] = 8'd1;
`else
      n = 2;
      ea[0] = 32'h0FF0; el[0] = 8'd15;
      ea[1] = 32'h1070; el[1] = 8'd3;
      ea[2] = 32'h0;    el[2] = 8'd0;
`endif
      start_cfg(32'h0FF0, 32'd40);
      for (int i = 0; i < n; i++) begin
         capture_ar(a, l, ok);
         checks++;
         if (!ok || a !== ea[i] || l !== el[i]) begin
            errors++;
            $display("FAIL split_ar%0d: seen=%b araddr=%h arlen=%0d required %h %0d",
                     i, ok, a, l, ea[i], el[i]);
         end
      end
      for (int i = 0; i < n; i++) pulse_rlast();
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL split_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_outstanding();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok;
      int          early;
      logic [7:0]  el;
      start_cfg(32'h2000, 32'd200);
      for (int i = 0; i < 4; i++) begin
         capture_ar(a, l, ok);
         checks++;
         if (!ok || a !== 32'h2000 + 32'(i) * 32'h80 || l !== 8'd15) begin
            errors++;
            $display("FAIL outst_ar%0d: seen=%b araddr=%h arlen=%0d required %h 15",
                     i, ok, a, l, 32'h2000 + 32'(i) * 32'h80);
         end
      end
      early = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus_if.axi_arvalid) early++;
         step();
      end
      checks++;
      if (early !== 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL outst_stall: arvalid_cycles=%0d busy=%b required 0 1", early, busy);
      end
      for (int i = 4; i < 7; i++) begin
         pulse_rlast();
         capture_ar(a, l, ok);
         el = (i == 6) ? 8'd3 : 8'd15;
         checks++;
         if (!ok || a !== 32'h2000 + 32'(i) * 32'h80 || l !== el) begin
            errors++;
            $display("FAIL outst_ar%0d: seen=%b araddr=%h arlen=%0d required %h %0d",
                     i, ok, a, l, 32'h2000 + 32'(i) * 32'h80, el);
         end
      end
      repeat (4) pulse_rlast();
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL outst_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_ar_backpressure();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok;
      int          bad;
      bus_if.axi_arready = 1'b0;
      start_cfg(32'h3000, 32'd64);
      wait_arvalid(ok);
      a = bus_if.axi_araddr;
      l = bus_if.axi_arlen;
      checks++;
      if (!ok || a !== 32'h3000 || l !== 8'd15) begin
         errors++;
         $display("FAIL bp_first: seen=%b araddr=%h arlen=%0d required 3000 15", ok, a, l);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus_if.axi_arvalid !== 1'b1 || bus_if.axi_araddr !== a || bus_if.axi_arlen !== l) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL bp_stable: unstable_cycles=%0d required 0", bad);
      end
      bus_if.axi_arready = 1'b1;
      step();
      bus_if.axi_arready = 1'b0;
      wait_arvalid(ok);
      checks++;
      if (!ok || bus_if.axi_araddr !== 32'h3080) begin
         errors++;
         $display("FAIL bp_second: seen=%b araddr=%h required 3080", ok, bus_if.axi_araddr);
      end
      // Second AR handshakes in the same cycle the first burst's rlast returns.
      bus_if.axi_arready = 1'b1;
      bus_if.axi_rvalid  = 1'b1;
      bus_if.axi_rready  = 1'b1;
      bus_if.axi_rlast   = 1'b1;
      step();
      bus_if.axi_rvalid  = 1'b0;
      bus_if.axi_rready  = 1'b0;
      bus_if.axi_rlast   = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy !== 1'b1) bad++;
         step();
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL bp_same_cycle_hold: idle_cycles=%0d required 0", bad);
      end
      pulse_rlast();
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_same_cycle_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok;
      bus_if.axi_arready = 1'b0;
      start_cfg(32'h5000, 32'd64);
      wait_arvalid(ok);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (!ok || bus_if.axi_arvalid !== 1'b0 || bus_if.cfg_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: reached_addr=%b arvalid=%b cfg_ready=%b busy=%b required 1 0 1 0",
                  ok, bus_if.axi_arvalid, bus_if.cfg_ready, busy);
      end
      bus_if.axi_arready = 1'b1;
      start_cfg(32'h4000, 32'd2);
      checks++;
      if (bus_if.data_cfg_valid !== 1'b1 || bus_if.data_cfg_length !== 32'd2) begin
         errors++;
         $display("FAIL rst_new_cfg: dvalid=%b dlen=%0d required 1 2",
                  bus_if.data_cfg_valid, bus_if.data_cfg_length);
      end
      capture_ar(a, l, ok);
      checks++;
      if (!ok || a !== 32'h4000 || l !== 8'd0) begin
         errors++;
         $display("FAIL rst_new_ar: seen=%b araddr=%h arlen=%0d required 4000 0", ok, a, l);
      end
      pulse_rlast();
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_new_idle: busy=%b required 0", busy);
      end
   endtask

   initial begin
      rst                   = 1'b1;
      bus_if.cfg_address    = '0;
      bus_if.cfg_length     = '0;
      bus_if.cfg_valid      = 1'b0;
      bus_if.data_cfg_ready = 1'b1;
      bus_if.axi_arready    = 1'b1;
      bus_if.axi_rvalid     = 1'b0;
      bus_if.axi_rready     = 1'b0;
      bus_if.axi_rlast      = 1'b0;
      test_reset();
      test_basic();
      test_zero_len();
      test_4k_split();
      test_outstanding();
      test_ar_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
